channel_gather_16: RTL



---
 rtl/channel_gather_16_pkg.sv | 23 ++
 rtl/channel_gather_16_frame_ctr.sv | 35 +++
 rtl/channel_gather_16.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/channel_gather_16_pkg.sv
// Shared lane geometry, state encoding and lane-counter helper for channel_gather_16.
package channel_gather_16_pkg;

   localparam int LANES  = 16;
   localparam int WORD_W = 32;
   localparam int LANE_W = 4;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } gather_state_e;

   typedef logic [LANES-1:0][WORD_W-1:0] lane_vec_t;

   // A frame-start word always restarts the group at lane 0, so the next free lane is 1.
   function automatic logic [LANE_W-1:0] lane_next(input logic [LANE_W-1:0] cnt,
                                                   input logic              sof);
      return sof ? LANE_W'(1) : LANE_W'(cnt + 1'b1);
   endfunction

endpackage

// File: rtl/channel_gather_16_frame_ctr.sv
// gather_frame_ctr: vector-in-frame counter driving the o_sof and frame_done terms.
module gather_frame_ctr #(
   parameter int FRAME_VECS = 16,
   parameter int CW         = (FRAME_VECS > 1) ? $clog2(FRAME_VECS) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic advance,
   input  logic sync,
   input  logic valid,
   output logic sof,
   output logic frame_done
);

   localparam logic [CW-1:0] LAST_VEC = CW'(FRAME_VECS - 1);

   logic [CW-1:0] vec_cnt;

   // sync wins over advance: a frame restart that lands on a transfer still starts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= advance && (vec_cnt == LAST_VEC);
         if (sync)
            vec_cnt <= '0;
         else if (advance)
            vec_cnt <= (vec_cnt == LAST_VEC) ? '0 : vec_cnt + 1'b1;
      end
   end

   assign sof = valid && (vec_cnt == '0);

endmodule

// File: rtl/channel_gather_16.sv
// channel_gather_16: packs 16 consecutive FP32 stream words into one lane vector.
// `define GATHER_SKID_EN adds a second lane bank so filling continues while a vector is held.
module channel_gather_16
   import channel_gather_16_pkg::*;
#(
   parameter int INPUT_X = 4,
   parameter int INPUT_Y = INPUT_X
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              output_valid,
   output logic [WORD_W-1:0] data_out_0,
   output logic [WORD_W-1:0] data_out_1,
   output logic [WORD_W-1:0] data_out_2,
   output logic [WORD_W-1:0] data_out_3,
   output logic [WORD_W-1:0] data_out_4,
   output logic [WORD_W-1:0] data_out_5,
   output logic [WORD_W-1:0] data_out_6,
   output logic [WORD_W-1:0] data_out_7,
   output logic [WORD_W-1:0] data_out_8,
   output logic [WORD_W-1:0] data_out_9,
   output logic [WORD_W-1:0] data_out_10,
   output logic [WORD_W-1:0] data_out_11,
   output logic [WORD_W-1:0] data_out_12,
   output logic [WORD_W-1:0] data_out_13,
   output logic [WORD_W-1:0] data_out_14,
   output logic [WORD_W-1:0] data_out_15,
   output logic              o_sof,
   output logic              frame_done,
   output logic              sof_err
);

   localparam int FRAME_VECS = INPUT_X * INPUT_Y;
   localparam int CW         = (FRAME_VECS > 1) ? $clog2(FRAME_VECS) : 1;

   logic [LANE_W-1:0] lane_cnt;
   logic [LANE_W-1:0] wr_lane;
   logic              word_acc;
   logic              sof_acc;
   logic              out_xfer;
   logic              vec_done;
   logic              sync;
   logic              sync_pend;
   lane_vec_t         vec_out;

   assign word_acc = in_valid && in_ready;
   assign sof_acc  = word_acc && in_sof;
   assign out_xfer = output_valid && out_ready;
   assign wr_lane  = in_sof ? '0 : lane_cnt;
   assign vec_done = !in_sof && (lane_cnt == LAST_LANE);

   // Restart the frame count now unless a vector from the old frame is still presented.
   assign sync = (sof_acc && (!output_valid || out_xfer)) || (out_xfer && sync_pend);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_cnt <= '0;
         sof_err  <= 1'b0;
      end else if (word_acc) begin
         lane_cnt <= lane_next(lane_cnt, in_sof);
         if (in_sof && (lane_cnt != '0))
            sof_err <= 1'b1;
      end
   end

`ifdef GATHER_SKID_EN
   logic [1:0][LANES-1:0][WORD_W-1:0] bank;
   logic [1:0]                        full;
   logic                              fill_sel;
   logic                              out_sel;

   // Banks are consumed in fill order, so the fill bank is only full when both are.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank      <= '0;
         full      <= '0;
         fill_sel  <= 1'b0;
         out_sel   <= 1'b0;
         sync_pend <= 1'b0;
      end else begin
         if (word_acc) begin
            bank[fill_sel][wr_lane] <= in_data;
            if (vec_done) begin
               full[fill_sel] <= 1'b1;
               fill_sel       <= ~fill_sel;
            end
         end
         if (out_xfer) begin
            full[out_sel] <= 1'b0;
            out_sel       <= ~out_sel;
         end
         if (out_xfer)
            sync_pend <= 1'b0;
         else if (sof_acc && output_valid)
            sync_pend <= 1'b1;
      end
   end

   assign in_ready     = !full[fill_sel];
   assign output_valid = full[out_sel];
   assign vec_out      = bank[out_sel];
`else
   gather_state_e state;
   lane_vec_t     lanes;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
         lanes <= '0;
      end else begin
         case (state)
            FILL: if (word_acc) begin
               lanes[wr_lane] <= in_data;
               if (vec_done)
                  state <= HOLD;
            end
            HOLD: if (out_ready)
               state <= FILL;
            default: state <= FILL;
         endcase
      end
   end

   assign in_ready     = (state == FILL);
   assign output_valid = (state == HOLD);
   assign vec_out      = lanes;
   assign sync_pend    = 1'b0;
`endif

   gather_frame_ctr #(
      .FRAME_VECS(FRAME_VECS),
      .CW        (CW)
   ) u_frame_ctr (
      .clk       (clk),
      .rst       (rst),
      .advance   (out_xfer),
      .sync      (sync),
      .valid     (output_valid),
      .sof       (o_sof),
      .frame_done(frame_done)
   );

   assign data_out_0  = vec_out[0];
   assign data_out_1  = vec_out[1];
   assign data_out_2  = vec_out[2];
   assign data_out_3  = vec_out[3];
   assign data_out_4  = vec_out[4];
   assign data_out_5  = vec_out[5];
   assign data_out_6  = vec_out[6];
   assign data_out_7  = vec_out[7];
   assign data_out_8  = vec_out[8];
   assign data_out_9  = vec_out[9];
   assign data_out_10 = vec_out[10];
   assign data_out_11 = vec_out[11];
   assign data_out_12 = vec_out[12];
   assign data_out_13 = vec_out[13];
   assign data_out_14 = vec_out[14];
   assign data_out_15 = vec_out[15];

endmodule
